seq_div32: RTL and testbench

- Multi-cycle radix-2 restoring divider for DIV/DIVU in the CPU datapath.
- Sits in the execute stage, directly upstream of the writeback result mux: its quotient and remainder registers feed the 32-bit 2:1 select that picks LO (quotient) or HI (remainder) for the register file.
- The control unit stalls the PC while `busy` is high.

---
 rtl/seq_div32_if.sv | 26 ++
 rtl/seq_div32.sv | 137 +++++++++++++
 tb/tb_seq_div32.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_div32_if.sv
// seq_div32_if: request/result bundle for the sequential divider.
//   master : drives start, is_signed, a, b; observes busy, done, q, r, div_by_zero
//   slave  : the divider itself
interface seq_div32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             div_by_zero;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, q, r, div_by_zero
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, q, r, div_by_zero
  );
endinterface

// File: rtl/seq_div32.sv
// seq_div32: multi-cycle radix-2 restoring divider (DIV / DIVU).
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - seq_div32_if.slave: start/is_signed/a/b in, busy/done/q/r/div_by_zero out
// One restoring step per cycle on operand magnitudes; the sign fix is applied
// when the final step writes q/r, so results appear WIDTH cycles after start.
//
// state  | meaning
// S_IDLE | waiting for start; q/r/div_by_zero hold the last result
// S_RUN  | WIDTH restoring iterations in progress, busy=1
module seq_div32 #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst_n,
  seq_div32_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             r_sa;
  logic             r_sb;
  logic             r_zero;
  logic [WIDTH-1:0] r_bmag;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dbz;
  logic             r_done;

  logic             w_load;
  logic             w_run;
  logic             w_last;
  logic             w_busy;
  logic [WIDTH-1:0] w_amag;
  logic [WIDTH-1:0] w_bmag;
  logic [WIDTH:0]   w_shift_rem;
  logic [WIDTH:0]   w_trial;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quot_nxt;

  // Magnitudes; the most negative value maps onto itself, which is the
  // correct unsigned magnitude.
  assign w_amag = (bus.is_signed && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
  assign w_bmag = (bus.is_signed && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;

  // Restoring step: bring the next dividend bit into the partial remainder
  // and subtract the divisor at WIDTH+1 bits so the borrow is the sign.
  assign w_shift_rem = {r_rem, r_dvd[WIDTH-1]};
  assign w_trial     = w_shift_rem - {1'b0, r_bmag};
  assign w_qbit      = ~w_trial[WIDTH];
  assign w_rem_nxt   = w_qbit ? w_trial[WIDTH-1:0] : w_shift_rem[WIDTH-1:0];
  assign w_quot_nxt  = {r_dvd[WIDTH-2:0], w_qbit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_run       = 1'b0;
    w_last      = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        w_run  = 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_zero <= 1'b0;
      r_bmag <= '0;
      r_rem  <= '0;
      r_dvd  <= '0;
      r_cnt  <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_dbz  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_load) begin
        r_sa   <= bus.is_signed & bus.a[WIDTH-1];
        r_sb   <= bus.is_signed & bus.b[WIDTH-1];
        r_zero <= (bus.b == '0);
        r_bmag <= w_bmag;
        r_dvd  <= w_amag;
        r_rem  <= '0;
        r_cnt  <= '0;
      end else if (w_run) begin
        r_rem <= w_rem_nxt;
        r_dvd <= w_quot_nxt;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_last) begin
        r_q   <= (r_sa ^ r_sb) ? (~w_quot_nxt + 1'b1) : w_quot_nxt;
        r_r   <= r_sa ? (~w_rem_nxt + 1'b1) : w_rem_nxt;
        r_dbz <= r_zero;
      end
    end
  end

  assign bus.busy        = w_busy;
  assign bus.done        = r_done;
  assign bus.q           = r_q;
  assign bus.r           = r_r;
  assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_div32.sv
// tb_seq_div32: directed table, handshake/reset sequences and random
// operations checked against an arithmetic reference model.
module tb_seq_div32;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_div32_if #(.WIDTH(32)) bus();
  seq_div32 #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  // Reference: plain integer division with MIPS truncation; divide-by-zero
  // and overflow results written out directly.
  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic z);
    int sa, sb;
    z = (b == 32'd0);
    if (b == 32'd0) begin
      r = a;
      q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      sa = a;
      sb = b;
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.is_signed = s;
    bus.a = a;
    bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.is_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(output int busy_cyc, output bit ok);
    int n;
    busy_cyc = 0;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 40) begin
      if (bus.done) ok = 1'b1;
      else begin
        if (bus.busy) busy_cyc++;
        @(negedge clk);
        n++;
      end
    end
  endtask

  task automatic do_op(input string nm, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input bit check_lat);
    logic [31:0] eq, er;
    logic ez;
    int bc;
    bit ok;
    model(s, a, b, eq, er, ez);
    launch(s, a, b);
    wait_done(bc, ok);
    if (!ok) chk({nm, " done_timeout"}, 32'd0, 32'd1);
    chk({nm, " q"}, bus.q, eq);
    chk({nm, " r"}, bus.r, er);
    chk({nm, " dbz"}, {31'd0, bus.div_by_zero}, {31'd0, ez});
    if (check_lat) begin
      chk({nm, " busy_cycles"}, bc, 32'd32);
      @(negedge clk);
      chk({nm, " done_width"}, {31'd0, bus.done}, 32'd0);
    end
  endtask

  vec_t vecs[10];

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, ndone;
    bit ok;
    logic [31:0] ra, rb;
    logic rs;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[2] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    vecs[3] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
    vecs[4] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0};
    vecs[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    vecs[6] = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
    vecs[7] = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
    vecs[8] = '{1'b1, 32'hFFFF_FFF6,  32'd0,          32'd1,          32'hFFFF_FFF6,  1'b1};
    vecs[9] = '{1'b1, 32'd10,         32'd0,          32'hFFFF_FFFF,  32'd10,         1'b1};

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.is_signed = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", {31'd0, bus.busy}, 32'd0);
    chk("rst done", {31'd0, bus.done}, 32'd0);
    chk("rst q", bus.q, 32'd0);
    chk("rst r", bus.r, 32'd0);
    chk("rst dbz", {31'd0, bus.div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].s, vecs[i].a, vecs[i].b);
      wait_done(bc, ok);
      if (!ok) chk($sformatf("vec%0d done_timeout", i), 32'd0, 32'd1);
      chk($sformatf("vec%0d q", i), bus.q, vecs[i].q);
      chk($sformatf("vec%0d r", i), bus.r, vecs[i].r);
      chk($sformatf("vec%0d dbz", i), {31'd0, bus.div_by_zero}, {31'd0, vecs[i].z});
      chk($sformatf("vec%0d busy_cycles", i), bc, 32'd32);
      @(negedge clk);
      chk($sformatf("vec%0d done_width", i), {31'd0, bus.done}, 32'd0);
      chk($sformatf("vec%0d hold_q", i), bus.q, vecs[i].q);
    end

    // start while busy is ignored
    launch(1'b0, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.a = 32'd50;
    bus.b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 32'h1234_5678;
    bus.b = 32'd3;
    wait_done(bc, ok);
    if (!ok) chk("ignore done_timeout", 32'd0, 32'd1);
    chk("ignore q", bus.q, 32'd14);
    chk("ignore r", bus.r, 32'd2);
    ndone = 0;
    @(negedge clk);
    for (int i = 0; i < 45; i++) begin
      if (bus.done) ndone++;
      @(negedge clk);
    end
    chk("ignore extra_done", ndone, 32'd0);

    // start accepted in the done cycle
    launch(1'b0, 32'd100, 32'd7);
    wait_done(bc, ok);
    if (!ok) chk("b2b first_timeout", 32'd0, 32'd1);
    chk("b2b first_q", bus.q, 32'd14);
    bus.start = 1'b1;
    bus.is_signed = 1'b0;
    bus.a = 32'd50;
    bus.b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    bc = 1;
    while (!bus.done && bc < 45) begin
      @(negedge clk);
      bc++;
    end
    chk("b2b spacing", bc, 32'd33);
    chk("b2b q", bus.q, 32'd10);
    chk("b2b r", bus.r, 32'd0);
    @(negedge clk);

    // reset mid-operation
    launch(1'b0, 32'd123456, 32'd789);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst q", bus.q, 32'd0);
    chk("midrst r", bus.r, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 45; i++) begin
      if (bus.done || bus.busy) ndone++;
      @(negedge clk);
    end
    chk("midrst activity", ndone, 32'd0);
    chk("midrst q_after", bus.q, 32'd0);
    chk("midrst r_after", bus.r, 32'd0);

    // random operations against the model
    for (int i = 0; i < 150; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(1, 15);
        3: begin ra = 32'h8000_0000; rb = $urandom; end
        4: begin ra = $urandom_range(0, 100); rb = $urandom_range(1, 200); end
        default: rb = $urandom;
      endcase
      do_op($sformatf("rnd%0d", i), rs, ra, rb, (i % 10) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
